// File: rtl/dac_serial_driver_if.sv
// dac_serial_driver_if
//   Bundles the control and DAC pin signals of dac_serial_driver.
//   slave  : the driver itself (takes en/sample_data, drives everything else)
//   master : the upstream/board side (drives en/sample_data, observes the rest)
//   en           - enables the sample timer
//   sample_data  - 8-bit waveform value from the lookup stage
//   sample_taken - one-cycle pulse in the capture cycle
//   busy         - frame or inter-frame gap in progress
//   done         - one-cycle pulse after frame + gap complete
//   overrun      - sticky, tick arrived while a tick was still pending
//   dac_sync_n   - DAC frame sync, active low
//   dac_sclk     - DAC serial clock, idles high
//   dac_din      - DAC serial data, MSB first
interface dac_serial_driver_if;
  logic       en;
  logic [7:0] sample_data;
  logic       sample_taken;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       dac_sync_n;
  logic       dac_sclk;
  logic       dac_din;

  modport slave (
    input  en, sample_data,
    output sample_taken, busy, done, overrun, dac_sync_n, dac_sclk, dac_din
  );

  modport master (
    output en, sample_data,
    input  sample_taken, busy, done, overrun, dac_sync_n, dac_sclk, dac_din
  );
endinterface

// File: rtl/dac_serial_driver.sv
// dac_serial_driver
//   Owns the output sample rate: every SAMPLE_DIV cycles (while en=1) a tick
//   queues one frame. The 8-bit sample is left-justified into a 16-bit
//   DAC121S101-style word {4'b0000, sample, 4'b0000} and shifted out MSB first
//   on SYNC_n/SCLK/DIN, followed by a SYNC_n-high gap.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - dac_serial_driver_if.slave (control handshake and DAC pins)
module dac_serial_driver #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4,
  parameter int SAMPLE_DIV = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dac_serial_driver_if.slave   bus
);

  localparam int TW   = $clog2(SAMPLE_DIV);
  localparam int DMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_HI, SHIFT_LO, GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick_cnt;
  logic          r_pending;
  logic          r_overrun;
  logic [DW-1:0] r_div_cnt, w_div_nxt;
  logic [3:0]    r_bit_cnt, w_bit_nxt;
  logic [15:0]   r_shift, w_shift_nxt;
  logic          r_sync_n, r_sclk, r_din, r_busy, r_done;
  logic          w_tick, w_capture, w_done_nxt, w_shifting_nxt;

  assign w_tick    = bus.en && (r_tick_cnt == TICK_LAST);
  assign w_capture = (r_state == IDLE) && r_pending;

  // Sample timer. A tick in the capture cycle re-arms pending (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (!bus.en) begin
      r_tick_cnt <= '0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick)
        r_pending <= 1'b1;
      else if (w_capture)
        r_pending <= 1'b0;
      if (w_tick && r_pending)
        r_overrun <= 1'b1;
    end
  end

  // Frame FSM state and registered DAC pins. Pins are derived from the
  // next state so they change on the same edge the FSM does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_sync_n  <= 1'b1;
      r_sclk    <= 1'b1;
      r_din     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_sync_n  <= !w_shifting_nxt;
      r_sclk    <= (w_state_nxt != SHIFT_LO);
      r_din     <= w_shifting_nxt ? w_shift_nxt[15] : 1'b0;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_shift_nxt = {4'b0000, bus.sample_data, 4'b0000};
          w_bit_nxt   = 4'd15;
          w_div_nxt   = '0;
          w_state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (r_div_cnt == HALF_LAST) begin
          w_div_nxt   = '0;
          w_state_nxt = SHIFT_LO;
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (r_div_cnt == HALF_LAST) begin
          w_div_nxt = '0;
          if (r_bit_cnt == 4'd0) begin
            w_state_nxt = GAP;
          end else begin
            // Shift only on the low->high SCLK transition so DIN is stable
            // across the falling edge the DAC samples on.
            w_shift_nxt = {r_shift[14:0], 1'b0};
            w_bit_nxt   = r_bit_cnt - 1'b1;
            w_state_nxt = SHIFT_HI;
          end
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (r_div_cnt == GAP_LAST) begin
          w_div_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_shifting_nxt = (w_state_nxt == SHIFT_HI) || (w_state_nxt == SHIFT_LO);

  assign bus.sample_taken = w_capture;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.overrun      = r_overrun;
  assign bus.dac_sync_n   = r_sync_n;
  assign bus.dac_sclk     = r_sclk;
  assign bus.dac_din      = r_din;

endmodule

// File: tb/tb_dac_serial_driver.sv
module tb_dac_serial_driver;

  localparam int FRAME_DONE_LAT = 69;  // capture -> done with CLK_DIV=2, GAP=4

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_serial_driver_if if0();
  dac_serial_driver_if if1();

  dac_serial_driver #(.CLK_DIV(2), .GAP_CYCLES(4), .SAMPLE_DIV(100)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  dac_serial_driver #(.CLK_DIV(2), .GAP_CYCLES(4), .SAMPLE_DIV(40)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  // Sample data sources: DUT0 directed or random-per-cycle, DUT1 random.
  logic       rand_mode0 = 1'b0;
  logic [7:0] dir_data0  = 8'h00;
  logic [7:0] rnd0 = 8'h00, rnd1 = 8'h00;
  always @(posedge clk) begin
    #1;
    rnd0 = 8'($urandom);
    rnd1 = 8'($urandom);
  end
  assign if0.sample_data = rand_mode0 ? rnd0 : dir_data0;
  assign if1.sample_data = rnd1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Scoreboard: expected words and done cycles pushed at capture.
  logic [15:0] expw0[$], expw1[$];
  int          expd0[$], expd1[$];
  logic        prev_sync[2], prev_sclk[2], prev_din[2], glitch[2];
  int          nbits[2];
  logic [15:0] word[2];
  int          cap_cnt[2] = '{0, 0};
  int          done_cnt[2] = '{0, 0};
  int          last_cap[2] = '{0, 0};
  bit          last_valid0 = 1'b0;

  task automatic mon(input int k, input logic en, input logic st, input logic [7:0] sd,
                     input logic dn, input logic ov, input logic sync_n,
                     input logic sclk, input logic din);
    logic [15:0] w;
    int d;
    if (st === 1'b1) begin
      w = {4'b0000, sd, 4'b0000};
      if (k == 0) begin
        expw0.push_back(w);
        expd0.push_back(cyc + FRAME_DONE_LAT);
        check("overrun0_at_capture", ov, 0);
        if (last_valid0) check("tick_spacing0", cyc - last_cap[0], 100);
        last_valid0 = 1'b1;
      end else begin
        expw1.push_back(w);
        expd1.push_back(cyc + FRAME_DONE_LAT);
      end
      last_cap[k] = cyc;
      cap_cnt[k]++;
    end
    if (k == 0 && en !== 1'b1) last_valid0 = 1'b0;

    if (dn === 1'b1) begin
      done_cnt[k]++;
      if ((k == 0 && expd0.size() == 0) || (k == 1 && expd1.size() == 0)) begin
        check($sformatf("done_unexpected%0d", k), 1, 0);
      end else begin
        d = (k == 0) ? expd0.pop_front() : expd1.pop_front();
        check($sformatf("done_latency%0d", k), cyc, d);
      end
    end

    if (prev_sync[k] && !sync_n) begin
      nbits[k]  = 0;
      word[k]   = '0;
      glitch[k] = 1'b0;
    end else if (!prev_sync[k] && !sync_n) begin
      if (prev_sclk[k] && !sclk) begin
        word[k] = {word[k][14:0], din};
        nbits[k]++;
      end
      if (!prev_sclk[k] && !sclk && din !== prev_din[k]) glitch[k] = 1'b1;
    end else if (!prev_sync[k] && sync_n) begin
      check($sformatf("frame_bits%0d", k), nbits[k], 16);
      check($sformatf("din_stable_low%0d", k), glitch[k], 0);
      if ((k == 0 && expw0.size() == 0) || (k == 1 && expw1.size() == 0)) begin
        check($sformatf("frame_unexpected%0d", k), 1, 0);
      end else begin
        w = (k == 0) ? expw0.pop_front() : expw1.pop_front();
        check($sformatf("frame_word%0d", k), word[k], w);
      end
    end
    prev_sync[k] = sync_n;
    prev_sclk[k] = sclk;
    prev_din[k]  = din;
  endtask

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        prev_sync[k] = 1'b1;
        prev_sclk[k] = 1'b1;
        prev_din[k]  = 1'b0;
        nbits[k]     = 0;
        glitch[k]    = 1'b0;
      end
      expw0.delete(); expw1.delete();
      expd0.delete(); expd1.delete();
      last_valid0 = 1'b0;
    end else begin
      mon(0, if0.en, if0.sample_taken, if0.sample_data, if0.done, if0.overrun,
          if0.dac_sync_n, if0.dac_sclk, if0.dac_din);
      mon(1, if1.en, if1.sample_taken, if1.sample_data, if1.done, if1.overrun,
          if1.dac_sync_n, if1.dac_sclk, if1.dac_din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cap(input int k, input int budget);
    int c;
    bit ok;
    c  = cap_cnt[k];
    ok = 1'b0;
    repeat (budget) begin
      tick();
      if (cap_cnt[k] != c) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("timeout_capture%0d", k), 0, 1);
  endtask

  initial begin
    int e, t, d, c, viol;
    bit ok;
    logic [7:0] steps[3];
    steps[0] = 8'h00; steps[1] = 8'h80; steps[2] = 8'hFF;

    rst_n  = 1'b0;
    if0.en = 1'b0;
    if1.en = 1'b0;
    repeat (3) tick();
    check("rst_sync_n",  if0.dac_sync_n, 1);
    check("rst_sclk",    if0.dac_sclk, 1);
    check("rst_din",     if0.dac_din, 0);
    check("rst_busy",    if0.busy, 0);
    check("rst_done",    if0.done, 0);
    check("rst_taken",   if0.sample_taken, 0);
    check("rst_overrun", if0.overrun, 0);
    rst_n = 1'b1;

    // en low: DAC idle, no captures.
    viol = 0;
    c = cap_cnt[0];
    repeat (200) begin
      tick();
      if (if0.dac_sync_n !== 1'b1 || if0.dac_sclk !== 1'b1 ||
          if0.dac_din !== 1'b0 || if0.busy !== 1'b0) viol++;
    end
    check("idle_pins_en0", viol, 0);
    check("idle_no_capture", cap_cnt[0] - c, 0);

    // First frame 0xA5, then directed steps, then random data.
    dir_data0 = 8'hA5;
    if0.en    = 1'b1;
    e         = cyc;
    wait_cap(0, 250);
    check("first_capture_latency", last_cap[0] - e, 100);
    for (int i = 0; i < 3; i++) begin
      dir_data0 = steps[i];
      wait_cap(0, 250);
    end
    rand_mode0 = 1'b1;
    repeat (3) wait_cap(0, 250);

    // Drop en during SHIFT_LO of bit 7: frame completes, nothing further.
    wait_cap(0, 250);
    t = last_cap[0];
    while (cyc < t + 35) tick();
    if0.en = 1'b0;
    d = done_cnt[0];
    c = cap_cnt[0];
    repeat (300) tick();
    check("en_drop_done", done_cnt[0] - d, 1);
    check("en_drop_no_capture", cap_cnt[0] - c, 0);

    // Asynchronous reset 30 cycles into a frame.
    if0.en = 1'b1;
    wait_cap(0, 250);
    t = last_cap[0];
    while (cyc < t + 30) tick();
    check("midframe_sync_low", if0.dac_sync_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sync_n", if0.dac_sync_n, 1);
    check("async_rst_sclk",   if0.dac_sclk, 1);
    check("async_rst_din",    if0.dac_din, 0);
    check("async_rst_busy",   if0.busy, 0);
    check("async_rst_done",   if0.done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_cap(0, 250);
    d  = done_cnt[0];
    ok = 1'b0;
    repeat (200) begin
      tick();
      if (done_cnt[0] != d) begin
        ok = 1'b1;
        break;
      end
    end
    check("post_reset_frame_done", ok, 1);
    if0.en = 1'b0;

    // Too-short SAMPLE_DIV: overrun must rise, frames stay well-formed.
    check("dut1_overrun_initial", if1.overrun, 0);
    if1.en = 1'b1;
    repeat (400) tick();
    check("dut1_overrun_set", if1.overrun, 1);
    check("dut1_frames_seen", (cap_cnt[1] >= 4), 1);
    if1.en = 1'b0;
    tick();
    check("dut1_overrun_clear", if1.overrun, 0);
    repeat (150) tick();

    check("pending_words0", expw0.size(), 0);
    check("pending_words1", expw1.size(), 0);
    check("pending_done0",  expd0.size(), 0);
    check("pending_done1",  expd1.size(), 0);
    check("final_busy0", if0.busy, 0);
    check("final_busy1", if1.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
